// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and default widths for the data memory arbiter
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory arbiter: pipeline priority, starvation-bounded debug port
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              dbg_grant;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    dbg_rdata_d  = dbg_rdata_q;
    dbg_grant    = (state_q == ST_IDLE) && dbg_req &&
                   (!pipe_req || (starve_cnt_q == CNT_MAX));

    case (state_q)
      ST_IDLE: begin
        if (dbg_grant) begin
          state_d      = ST_ACK;
          starve_cnt_d = '0;
          if (!dbg_we) dbg_rdata_d = mem_dout;
        end else if (!dbg_req) begin
          starve_cnt_d = '0;
        end else if (pipe_req && (starve_cnt_q != CNT_MAX)) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end
      // Pipeline always owns the ACK cycle, so debug cannot win twice in a row.
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Strobes are gated by rst_n so memory stays untouched while reset is held.
  always_comb begin
    mem_addr   = dbg_grant ? dbg_addr  : pipe_addr;
    mem_din    = dbg_grant ? dbg_wdata : pipe_wdata;
    mem_we     = rst_n && (dbg_grant ? dbg_we : (pipe_req && pipe_we));
    pipe_stall = rst_n && pipe_req && dbg_grant;
    pipe_rdata = dbg_grant ? '0 : mem_dout;
  end

  assign dbg_ack   = (state_q == ST_ACK);
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized bench for dmem_arbiter against a cycle-level reference model
module tb_dmem_arbiter;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_req, pipe_we;
  logic [7:0]  pipe_addr;
  logic [31:0] pipe_wdata, pipe_rdata;
  logic        pipe_stall;
  logic        dbg_req, dbg_we;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_ack;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_we;

  logic [31:0] ram [256];
  logic [31:0] mdl_mem [256];

  int          total = 0;
  int          bad = 0;
  bit          in_ack;
  int          losses;
  int          age;
  logic [31:0] exp_rdata;
  bit          prev_stall;
  bit          last_stall, last_ack;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  // data_mem stand-in: write on the falling edge, asynchronous read
  always @(negedge clk) if (mem_we) ram[mem_addr] <= mem_din;
  assign mem_dout = ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    in_ack     = 0;
    losses     = 0;
    age        = 0;
    exp_rdata  = '0;
    prev_stall = 0;
  endtask

  // Called at posedge+1 with inputs settled; checks, advances the model, returns at next posedge+1.
  task automatic cycle_check();
    bit g;
    #1;
    g = !in_ack && dbg_req && (!pipe_req || losses == SMAX);
    last_stall = pipe_stall;
    last_ack   = dbg_ack;
    last_rdata = dbg_rdata;
    chk("dbg_ack", dbg_ack, in_ack);
    chk("dbg_rdata", dbg_rdata, exp_rdata);
    chk("mem_we", mem_we, g ? dbg_we : (pipe_req && pipe_we));
    if (g || pipe_req) chk("mem_addr", mem_addr, g ? dbg_addr : pipe_addr);
    if (g && dbg_we) chk("mem_din_dbg", mem_din, dbg_wdata);
    if (!g && pipe_req && pipe_we) chk("mem_din_pipe", mem_din, pipe_wdata);
    chk("pipe_stall", pipe_stall, pipe_req && g);
    if (g) chk("pipe_rdata_zero", pipe_rdata, 32'h0);
    else if (pipe_req && !pipe_we) chk("pipe_rdata", pipe_rdata, mdl_mem[pipe_addr]);
    if (pipe_stall && prev_stall) chk("stall_consec", 32'd1, 32'd0);
    prev_stall = pipe_stall;

    if (dbg_req && !in_ack) age++;
    else if (!dbg_req) age = 0;
    if (g) begin
      chk("dbg_latency_ok", 32'(age <= SMAX + 1), 32'd1);
      age = 0;
      if (dbg_we) mdl_mem[dbg_addr] = dbg_wdata;
      else exp_rdata = mdl_mem[dbg_addr];
      losses = 0;
      in_ack = 1;
    end else begin
      if (pipe_req && pipe_we) mdl_mem[pipe_addr] = pipe_wdata;
      if (!in_ack) losses = (dbg_req && pipe_req) ? ((losses < SMAX) ? losses + 1 : SMAX) : 0;
      in_ack = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stall_cyc, ack_cyc, grants;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = '0;
      mdl_mem[i] = '0;
    end
    rst_n = 0; pipe_req = 1; pipe_we = 1; pipe_addr = 8'h10; pipe_wdata = 32'h1234;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h11; dbg_wdata = 32'h55;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stall", pipe_stall, 0);
    chk("rst_ack", dbg_ack, 0);
    chk("rst_rdata", dbg_rdata, 0);
    @(posedge clk); #1;
    dbg_req = 0; pipe_req = 0; pipe_we = 0;
    rst_n = 1;
    cycle_check();

    // debug write with idle pipeline, request held through ack
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h10; dbg_wdata = 32'hDEADBEEF;
    cycle_check();
    chk("wr_ack", last_ack, 0);
    cycle_check();
    chk("wr_ack_next", last_ack, 1);
    grants = 0;
    cycle_check();
    if (last_ack == 0 && mem_we == 0) grants = 0;
    cycle_check();
    chk("regrant_ack", last_ack, 1);
    dbg_req = 0;
    pipe_req = 1; pipe_we = 0; pipe_addr = 8'h10;
    cycle_check();
    #1 chk("pipe_load_dbgw", pipe_rdata, 32'hDEADBEEF);
    #0;

    // starvation bound under continuous pipeline traffic
    pipe_addr = 8'h20;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h10;
    stall_cyc = -1; ack_cyc = -1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) dbg_req = 0;
      cycle_check();
      if (last_stall) stall_cyc = (stall_cyc < 0) ? i : 99;
      if (last_ack) begin
        ack_cyc = i;
        chk("starve_rdata", last_rdata, 32'hDEADBEEF);
      end
    end
    chk("starve_grant_cyc", stall_cyc, 4);
    chk("starve_ack_cyc", ack_cyc, 5);

    // abandoned request: two losing cycles then drop; next request must wait the full bound
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h30; dbg_wdata = 32'hBAD0BAD0;
    repeat (2) cycle_check();
    dbg_req = 0;
    repeat (2) cycle_check();
    chk("abandon_no_write", ram[8'h30], 32'h0);
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h10;
    stall_cyc = -1;
    for (int i = 0; i < 5; i++) begin
      cycle_check();
      if (last_stall && stall_cyc < 0) stall_cyc = i;
    end
    chk("abandon_cnt_cleared", stall_cyc, 4);
    dbg_req = 0;
    cycle_check();

    // reset while in ACK after a debug write
    pipe_req = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h40; dbg_wdata = 32'hCAFEF00D;
    cycle_check();
    rst_n = 0;
    #1;
    chk("midrst_ack_drop", dbg_ack, 0);
    dbg_req = 0; pipe_req = 1; pipe_we = 1;
    #1;
    chk("midrst_mem_we", mem_we, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1; pipe_we = 0; pipe_addr = 8'h40;
    chk("midrst_write_stands", ram[8'h40], 32'hCAFEF00D);
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h40;
    stall_cyc = -1;
    for (int i = 0; i < 6; i++) begin
      cycle_check();
      if (last_stall && stall_cyc < 0) stall_cyc = i;
    end
    chk("midrst_cnt_zero", stall_cyc, 4);
    dbg_req = 0;
    cycle_check();

    // randomized traffic; debug fields change only while the request is low
    for (int n = 0; n < 3000; n++) begin
      pipe_req   = ($urandom_range(0, 3) != 0);
      pipe_we    = $urandom_range(0, 1) == 1;
      pipe_addr  = 8'($urandom_range(0, 15));
      pipe_wdata = $urandom;
      if (dbg_req) begin
        if (in_ack) begin
          if ($urandom_range(0, 3) != 0) dbg_req = 0;
        end else if ($urandom_range(0, 15) == 0) begin
          dbg_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        dbg_req   = 1;
        dbg_we    = $urandom_range(0, 1) == 1;
        dbg_addr  = 8'($urandom_range(0, 15));
        dbg_wdata = $urandom;
      end
      cycle_check();
    end

    for (int i = 0; i < 16; i++) chk("final_mem", ram[i], mdl_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the pipeline MEM stage and a debug/loader port. The pipeline has priority. A starvation counter guarantees the debug port a slot within a bounded number of cycles. When the debug port takes the memory while the MEM stage needs it, the block stalls the pipeline for that cycle. The block sits between the MEM stage and `data_mem`, which keeps its 8-bit word address, 32-bit data and active-high write enable, clocked on `~clk`.

## Interface

Parameters:
- `ADDR_W` = 8 — data memory word-address width
- `DATA_W` = 32 — data width
- `STARVE_MAX` = 4 — maximum consecutive cycles a pending debug request may lose to the pipeline; 0 means debug always wins

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1 — system clock; all state updates on the rising edge
- `rst_n` in 1 — asynchronous active-low reset
- `pipe_req` in 1 — MEM stage performs a load or store this cycle
- `pipe_we` in 1 — MEM stage store
- `pipe_addr` in ADDR_W — MEM stage address (ALU result low bits)
- `pipe_wdata` in DATA_W — MEM stage store data
- `pipe_rdata` out DATA_W — load data to MEM stage
- `pipe_stall` out 1 — MEM access denied this cycle; pipeline holds
- `dbg_req` in 1 — debug access request, held until `dbg_ack`
- `dbg_we` in 1 — debug write
- `dbg_addr` in ADDR_W — debug address
- `dbg_wdata` in DATA_W — debug write data
- `dbg_ack` out 1 — one-cycle completion pulse
- `dbg_rdata` out DATA_W — registered debug read data
- `mem_addr` out ADDR_W — to `data_mem` address
- `mem_din` out DATA_W — to `data_mem` write data
- `mem_we` out 1 — to `data_mem` write enable
- `mem_dout` in DATA_W — from `data_mem` read data

## Operation

- **States:** IDLE (pipeline owns memory, debug eligible) and ACK (debug access finished, debug ineligible).
- **Grant:** `dbg_grant = (state==IDLE) && dbg_req && (!pipe_req || starve_cnt==STARVE_MAX)`. The grant is combinational and is the only cycle in which debug drives the memory.
- **Memory mux:**
  - `dbg_grant`=1: `mem_addr/mem_din` = debug fields, `mem_we = dbg_we`.
  - Otherwise: pipeline fields, with `mem_we = pipe_req && pipe_we`.
  - `mem_we` is never asserted for a non-granted requester.
- **Pipeline read/stall:**
  - `pipe_rdata = mem_dout` whenever not `dbg_grant`, else 0.
  - `pipe_stall = pipe_req && dbg_grant`.
- **Transitions:**
  - IDLE→ACK on `dbg_grant`.
  - ACK→IDLE unconditionally.
  - In ACK, `dbg_req` is ignored even if still high.
- **Debug completion:**
  - At the rising edge ending the grant cycle: `dbg_rdata <= mem_dout` on reads, unchanged on writes.
  - `dbg_ack` = (state==ACK).
- **`starve_cnt`** (width = clog2(STARVE_MAX+1), minimum 1):
  - Increments, saturating at `STARVE_MAX`, when state==IDLE && `dbg_req` && `pipe_req` && !`dbg_grant`.
  - Clears on `dbg_grant` or when `dbg_req`=0.
  - Holds in ACK.
- **Requester obligations:**
  - Debug keeps all `dbg_*` fields stable while `dbg_req` is high.
  - Dropping `dbg_req` before ack abandons the request; the counter clears and there is no side effect unless the grant already occurred.

## Timing

- **Reset values:** state=IDLE, `starve_cnt`=0, `dbg_ack`=0, `dbg_rdata`=0.
- **Reset combinational outputs:** `pipe_stall`=0 and `mem_we`=0 while `rst_n`=0, regardless of inputs.
- **Debug latency:**
  - Request to ack: 1 cycle if the pipeline is idle.
  - Worst case under continuous pipeline traffic: STARVE_MAX+1 cycles.
- **Throughput:** minimum 2 cycles between debug grants (ACK gap); the pipeline always owns the ACK cycle.
- **Stall length:** the pipeline is stalled at most 1 cycle per debug grant, and never in two consecutive cycles.
- **Reset during ACK:** the ack is lost and the memory write already done stands; debug must reissue.
- **Simultaneous requests:** `pipe_req` and `dbg_req` both high with `starve_cnt`<MAX: pipeline wins, no stall.

## Structure

- Package `dmem_pkg`: state enum (`ST_IDLE`, `ST_ACK`) and the default `ADDR_W`/`DATA_W` constants shared with the MEM stage.
- Single module, no sub-modules. The starvation counter is small enough to stay inline.

## Test plan

- **Reset:** hold `rst_n`=0 with `pipe_req`=`pipe_we`=1 → `mem_we`=0, `pipe_stall`=0, `dbg_ack`=0, `dbg_rdata`=0.
- **Debug write, idle pipeline:** `pipe_req`=0; `dbg_req`=1, we=1, addr=0x10, wdata=0xDEADBEEF → same cycle `mem_we`=1, `mem_addr`=0x10; next cycle `dbg_ack`=1. A following pipeline load of 0x10 returns 0xDEADBEEF.
- **Starvation bound:** `STARVE_MAX`=4; `pipe_req`=1 every cycle; `dbg_req`=1 read at 0x10 from cycle 0 → grant in cycle 4 with `pipe_stall`=1 only in cycle 4; `dbg_ack` in cycle 5 with `dbg_rdata`=0xDEADBEEF.
- **Held request:** `dbg_req` kept high through ack → no second grant in the ACK cycle; re-grant no earlier than 2 cycles after the first grant.
- **Abandoned request:** `dbg_req` high for 2 cycles under pipeline traffic, then low → `starve_cnt` returns to 0, no ack, no memory write from debug.
- **Mid-operation reset:** assert `rst_n`=0 during ACK → `dbg_ack` drops immediately; after release state=IDLE, `starve_cnt`=0.
